// File: rtl/cnt_sequencer.sv
// rtl/cnt_sequencer.sv - one-shot/periodic counter sequencer with pause, abort, tick and done pulses.
// Optional step prescaler is built when CNT_SEQUENCER_PRESCALER_EN is defined.
module cnt_sequencer #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             hold_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [PRE_W-1:0] prescale_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             step;

`ifdef CNT_SEQUENCER_PRESCALER_EN
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_cnt;

    assign step = (pre_cnt == pre_q);

    // Divider only advances in unpaused RUN; start and stop realign it.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            pre_q   <= '0;
            pre_cnt <= '0;
        end else if (stop_i) begin
            pre_cnt <= '0;
        end else if (state == IDLE && start_i) begin
            pre_q   <= prescale_i;
            pre_cnt <= '0;
        end else if (state == RUN && !hold_i) begin
            pre_cnt <= step ? '0 : pre_cnt + PRE_W'(1);
        end
    end
`else
    logic unused_prescale;

    assign step            = 1'b1;
    assign unused_prescale = ^prescale_i;
`endif

    assign state_o = state;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state   <= IDLE;
            cnt_o   <= '0;
            busy_o  <= 1'b0;
            tick_o  <= 1'b0;
            done_o  <= 1'b0;
            limit_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            done_o <= 1'b0;
            if (stop_i) begin
                state  <= IDLE;
                cnt_o  <= '0;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_o <= '0;
                        if (start_i) begin
                            limit_q <= limit_i;
                            mode_q  <= mode_i;
                            state   <= RUN;
                            busy_o  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (hold_i) begin
                            state <= PAUSE;
                        end else if (step) begin
                            if (cnt_o != limit_q) begin
                                cnt_o <= cnt_o + WIDTH'(1);
                            end else if (mode_q) begin
                                cnt_o  <= '0;
                                tick_o <= 1'b1;
                            end else begin
                                done_o <= 1'b1;
                                state  <= DONE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!hold_i) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        cnt_o <= '0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt_sequencer.sv
// tb/tb_cnt_sequencer.sv - directed and randomized checks of cnt_sequencer against a cycle reference model.
module tb_cnt_sequencer;

    localparam int WIDTH = 4;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             hold = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic [PRE_W-1:0] prescale = '0;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             tick;
    logic             done;
    logic [1:0]       state;
    logic [8:0]       obs;

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers
    int m_state, m_cnt, m_lim, m_mode, m_pre, m_pc, m_tick, m_done;

    always #5 clk = ~clk;

    cnt_sequencer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .stop_i(stop),
        .hold_i(hold), .mode_i(mode), .limit_i(limit), .prescale_i(prescale),
        .cnt_o(cnt), .busy_o(busy), .tick_o(tick), .done_o(done), .state_o(state)
    );

    assign obs = {state, busy, tick, done, cnt};

    function automatic logic [8:0] pack(input int st, input int b, input int t, input int d, input int c);
        logic [1:0] s2 = st[1:0];
        logic [3:0] c4 = c[3:0];
        return {s2, b[0], t[0], d[0], c4};
    endfunction

    task automatic clock_in(input logic s, input logic p, input logic h, input logic m,
                            input int l, input int pre);
        start    = s;
        stop     = p;
        hold     = h;
        mode     = m;
        limit    = l[WIDTH-1:0];
        prescale = pre[PRE_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_state = 0; m_cnt = 0; m_lim = 0; m_mode = 0;
        m_pre = 0; m_pc = 0; m_tick = 0; m_done = 0;
    endtask

    // Spec rules applied once per clock edge to the inputs sampled at that edge.
    task automatic model_edge(input int s, input int p, input int h, input int m, input int l, input int pre);
        int stepped;
        m_tick = 0;
        m_done = 0;
        if (p != 0) begin
            m_state = 0; m_cnt = 0; m_pc = 0;
        end else if (m_state == 0) begin
            m_cnt = 0;
            if (s != 0) begin
                m_lim = l; m_mode = m; m_pc = 0; m_state = 1;
`ifdef CNT_SEQUENCER_PRESCALER_EN
                m_pre = pre;
`else
                m_pre = 0 * pre;
`endif
            end
        end else if (m_state == 1) begin
            if (h != 0) begin
                m_state = 2;
            end else begin
                stepped = (m_pc >= m_pre) ? 1 : 0;
                m_pc = stepped ? 0 : m_pc + 1;
                if (stepped != 0) begin
                    if (m_cnt < m_lim) m_cnt = m_cnt + 1;
                    else if (m_mode != 0) begin m_cnt = 0; m_tick = 1; end
                    else begin m_done = 1; m_state = 3; end
                end
            end
        end else if (m_state == 2) begin
            if (h == 0) m_state = 1;
        end else begin
            m_state = 0; m_cnt = 0;
        end
    endtask

    function automatic logic [8:0] model_obs();
        return pack(m_state, (m_state == 1 || m_state == 2) ? 1 : 0, m_tick, m_done, m_cnt);
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (obs !== 9'd0) begin errors++; $display("FAIL reset_initial: got %h want %h", obs, 9'd0); end
        #20 n_rst = 1'b1;
        clock_in(0, 0, 0, 0, 0, 0);
        clock_in(1, 0, 0, 0, 9, 0);
        clock_in(0, 0, 0, 0, 9, 0);
        clock_in(0, 0, 0, 0, 9, 0);
        checks++;
        if (obs !== pack(1, 1, 0, 0, 2)) begin errors++; $display("FAIL reset_prerun: got %h want %h", obs, pack(1, 1, 0, 0, 2)); end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (obs !== 9'd0) begin errors++; $display("FAIL reset_async: got %h want %h", obs, 9'd0); end
        #1 n_rst = 1'b1;
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 9'd0) begin errors++; $display("FAIL reset_after: got %h want %h", obs, 9'd0); end
    endtask

    task automatic test_oneshot();
        clock_in(1, 0, 0, 0, 5, 0);
        checks++;
        if (obs !== pack(1, 1, 0, 0, 0)) begin errors++; $display("FAIL oneshot_start: got %h want %h", obs, pack(1, 1, 0, 0, 0)); end
        for (int i = 1; i <= 5; i++) begin
            clock_in(0, 0, 0, 1, 2, 0);
            checks++;
            if (obs !== pack(1, 1, 0, 0, i)) begin errors++; $display("FAIL oneshot_cnt%0d: got %h want %h", i, obs, pack(1, 1, 0, 0, i)); end
        end
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(3, 0, 0, 1, 5)) begin errors++; $display("FAIL oneshot_done: got %h want %h", obs, pack(3, 0, 0, 1, 5)); end
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(0, 0, 0, 0, 0)) begin errors++; $display("FAIL oneshot_idle: got %h want %h", obs, pack(0, 0, 0, 0, 0)); end
    endtask

    task automatic test_periodic();
        int ticks = 0;
        int last = -100;
        clock_in(1, 0, 0, 1, 3, 0);
        for (int j = 1; j <= 12; j++) begin
            clock_in(0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== pack(1, 1, (j % 4 == 0) ? 1 : 0, 0, j % 4)) begin
                errors++; $display("FAIL periodic_cyc%0d: got %h want %h", j, obs, pack(1, 1, (j % 4 == 0) ? 1 : 0, 0, j % 4));
            end
            if (tick === 1'b1) begin
                ticks++;
                if (last >= 0) begin
                    checks++;
                    if (j - last != 4) begin errors++; $display("FAIL periodic_spacing: got %0d want %0d", j - last, 4); end
                end
                last = j;
            end
        end
        checks++;
        if (ticks != 3) begin errors++; $display("FAIL periodic_ticks: got %0d want %0d", ticks, 3); end
        clock_in(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_hold_stop();
        clock_in(1, 0, 0, 1, 9, 0);
        for (int j = 1; j <= 4; j++) clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(1, 1, 0, 0, 4)) begin errors++; $display("FAIL hold_pre: got %h want %h", obs, pack(1, 1, 0, 0, 4)); end
        for (int j = 0; j < 4; j++) begin
            clock_in(0, 0, 1, 0, 0, 0);
            checks++;
            if (obs !== pack(2, 1, 0, 0, 4)) begin errors++; $display("FAIL hold_frozen%0d: got %h want %h", j, obs, pack(2, 1, 0, 0, 4)); end
        end
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(1, 1, 0, 0, 4)) begin errors++; $display("FAIL hold_resume: got %h want %h", obs, pack(1, 1, 0, 0, 4)); end
        clock_in(0, 0, 0, 0, 0, 0);
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(1, 1, 0, 0, 6)) begin errors++; $display("FAIL hold_cnt6: got %h want %h", obs, pack(1, 1, 0, 0, 6)); end
        clock_in(1, 1, 0, 1, 9, 0);
        checks++;
        if (obs !== pack(0, 0, 0, 0, 0)) begin errors++; $display("FAIL stop_idle: got %h want %h", obs, pack(0, 0, 0, 0, 0)); end
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(0, 0, 0, 0, 0)) begin errors++; $display("FAIL stop_start_ignored: got %h want %h", obs, pack(0, 0, 0, 0, 0)); end
    endtask

    task automatic test_edges();
        clock_in(1, 0, 0, 0, 0, 0);
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(3, 0, 0, 1, 0)) begin errors++; $display("FAIL lim0_oneshot: got %h want %h", obs, pack(3, 0, 0, 1, 0)); end
        clock_in(0, 0, 0, 0, 0, 0);
        clock_in(1, 0, 0, 1, 0, 0);
        for (int j = 0; j < 3; j++) begin
            clock_in(0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== pack(1, 1, 1, 0, 0)) begin errors++; $display("FAIL lim0_periodic%0d: got %h want %h", j, obs, pack(1, 1, 1, 0, 0)); end
        end
        clock_in(0, 1, 0, 0, 0, 0);
        clock_in(1, 0, 0, 1, 15, 0);
        for (int j = 1; j <= 15; j++) clock_in(0, 0, 0, 0, 3, 0);
        checks++;
        if (obs !== pack(1, 1, 0, 0, 15)) begin errors++; $display("FAIL full_top: got %h want %h", obs, pack(1, 1, 0, 0, 15)); end
        clock_in(0, 0, 0, 0, 3, 0);
        checks++;
        if (obs !== pack(1, 1, 1, 0, 0)) begin errors++; $display("FAIL full_wrap: got %h want %h", obs, pack(1, 1, 1, 0, 0)); end
        clock_in(0, 1, 0, 0, 0, 0);
    endtask

`ifdef CNT_SEQUENCER_PRESCALER_EN
    task automatic test_prescale();
        clock_in(1, 0, 0, 0, 2, 2);
        for (int j = 1; j <= 8; j++) begin
            clock_in(0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== pack(1, 1, 0, 0, j / 3)) begin errors++; $display("FAIL prescale_cyc%0d: got %h want %h", j, obs, pack(1, 1, 0, 0, j / 3)); end
        end
        clock_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== pack(3, 0, 0, 1, 2)) begin errors++; $display("FAIL prescale_done: got %h want %h", obs, pack(3, 0, 0, 1, 2)); end
        clock_in(0, 0, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        int s, p, h, m, l, pre;
        int bad = 0;
        clock_in(0, 1, 0, 0, 0, 0);
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            s   = ($urandom_range(0, 99) < 30) ? 1 : 0;
            p   = ($urandom_range(0, 99) < 3) ? 1 : 0;
            h   = ($urandom_range(0, 99) < 15) ? 1 : 0;
            m   = $urandom_range(0, 1);
            l   = $urandom_range(0, 15);
            pre = $urandom_range(0, 3);
            clock_in(s[0], p[0], h[0], m[0], l, pre);
            model_edge(s, p, h, m, l, pre);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                bad++;
                if (bad <= 10) $display("FAIL random_cyc%0d: got %h want %h", n, obs, model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_hold_stop();
        test_edges();
`ifdef CNT_SEQUENCER_PRESCALER_EN
        test_prescale();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_sequencer.md
# cnt_sequencer

Control block that sequences a WIDTH-bit synchronous up counter for timer use. It latches a terminal limit and mode on start, runs the counter in one-shot or periodic mode, and supports pause/resume and abort. It emits single-cycle tick and done pulses. It sits between the system control logic and the counter datapath, and is the sole owner of the counter's clear and increment.

## Interface
- WIDTH, 4: counter and limit width in bits
- PRE_W, 4: prescaler width in bits
- clk_i  in  1  clock, all state on rising edge
- n_rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start request, sampled only in IDLE
- stop_i  in  1  abort request, any state
- hold_i  in  1  level; pause counting while high
- mode_i  in  1  0 = one-shot, 1 = periodic; latched on start
- limit_i  in  WIDTH  terminal count; latched on start
- prescale_i  in  PRE_W  step divider; latched on start, used only with the macro
- cnt_o  out  WIDTH  current count
- busy_o  out  1  high in RUN or PAUSE
- tick_o  out  1  one-cycle pulse on periodic wrap
- done_o  out  1  one-cycle pulse on one-shot completion
- state_o  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset values:
  - state IDLE; cnt_o, tick_o, done_o, busy_o are 0.
  - Latched limit, mode and prescale are 0.
- IDLE:
  - cnt_o = 0.
  - If start_i is high and stop_i is low, latch mode_i, limit_i and prescale_i, then go to RUN.
- RUN: on each step event:
  - If cnt_o != limit, increment cnt_o.
  - If cnt_o == limit and mode is periodic: cnt_o <= 0, tick_o <= 1, stay in RUN.
  - If cnt_o == limit and mode is one-shot: cnt_o holds at limit, done_o <= 1, go to DONE.
- RUN with hold_i high: go to PAUSE. A step is not taken on that edge.
- PAUSE:
  - cnt_o and the prescaler are frozen.
  - hold_i low returns to RUN. Counting resumes on the following step.
- DONE:
  - cnt_o holds at limit for exactly one cycle.
  - Then go to IDLE, where cnt_o clears to 0.
- stop_i high in any state:
  - Next state is IDLE and cnt_o <= 0.
  - tick_o and done_o are suppressed.
  - stop_i has priority over start_i, hold_i and the terminal action.
- start_i outside IDLE is ignored. A new limit_i or mode_i while busy has no effect.
- limit = 0:
  - Periodic mode ticks on every step.
  - One-shot mode completes on its first step.
- Counter arithmetic is unsigned and never exceeds limit. No other wrap path exists.

## Timing
- Step event with no prescaler: every RUN cycle with hold_i low.
- start_i seen at edge k:
  - state_o = RUN and busy_o = 1 after edge k, with cnt_o = 0.
  - cnt_o = 1 after edge k+1.
- One-shot with limit L:
  - cnt_o = L after edge k+L.
  - done_o = 1 and state DONE after edge k+L+1.
  - IDLE after edge k+L+2.
- Periodic with limit L: tick_o pulses once every L+1 steps, in the same cycle that cnt_o shows 0.
- tick_o and done_o are registered and are never high for more than one consecutive cycle.
- busy_o and state_o are registered outputs, consistent with each other every cycle.
- hold_i and stop_i take effect on the first edge at which they are sampled high.

## Configuration
- CNT_SEQUENCER_PRESCALER_EN defined:
  - A step event occurs once every (prescale + 1) RUN cycles.
  - The prescaler clears on start and on stop, and freezes in PAUSE.
  - prescale = 0 behaves identically to the macro being undefined.
- CNT_SEQUENCER_PRESCALER_EN undefined:
  - No prescaler logic is built.
  - prescale_i is present but ignored; a step occurs every RUN cycle.

## Test plan
- Reset mid-RUN, n_rst_i low asynchronously -> outputs are 0 and state_o = 0 before the next clock edge.
- One-shot, limit = 5, start pulse at edge k -> cnt_o = 0..5 over edges k..k+5, done_o high only after edge k+6, IDLE with cnt_o = 0 after edge k+7.
- Periodic, limit = 3, run 12 cycles -> tick_o pulses exactly 3 times, 4 cycles apart, with cnt_o = 0 at each pulse; done_o stays 0.
- Periodic, limit = 9: hold_i high for 4 cycles at cnt_o = 4, then stop_i together with start_i at cnt_o = 6 -> cnt_o frozen at 4 in state 2, then IDLE with cnt_o = 0, no tick, start ignored.
- Edge values:
  - limit = 0, one-shot -> done_o after the first step.
  - limit = 2^WIDTH-1, periodic -> full-range count with a tick at wrap.
  - limit_i changed mid-run -> no effect.
- With macro, prescale = 2, limit = 2, one-shot -> cnt_o advances every 3 cycles; done_o 9 cycles after RUN entry.
